// File: rtl/pwm_cfg_pkg.sv
// Shared constants and types for the PWM configuration bank and its write arbiter.
// The register map, requester ids and a saturating counter helper live here.
package pwm_cfg_pkg;

  localparam int ADDR_EN_REG_LO = 0;
  localparam int ADDR_EN_REG_HI = 1;
  localparam int ADDR_EN_PWM_LO = 2;
  localparam int ADDR_EN_PWM_HI = 3;
  localparam int ADDR_DUTY      = 4;
  localparam int NUM_EN_REGS    = 4;

  // Requester ids double as bit positions in the request/grant vectors.
  typedef enum logic {
    REQ_SPI = 1'b0,
    REQ_SEQ = 1'b1
  } req_id_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pwm_cfg_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: one-hot grant, combinational from requests
// and the identity of the last requester served.
module rr_arb2
  import pwm_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_t last_grant_reg;
  req_id_t last_grant_next;

  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt = 2'b00;
    if (req[REQ_SPI] && (!req[REQ_SEQ] || (last_grant_reg == REQ_SEQ)))
      gnt[REQ_SPI] = 1'b1;
    else if (req[REQ_SEQ])
      gnt[REQ_SEQ] = 1'b1;
  end

  always_comb begin
    last_grant_next = last_grant_reg;
    if (gnt[REQ_SPI])
      last_grant_next = REQ_SPI;
    else if (gnt[REQ_SEQ])
      last_grant_next = REQ_SEQ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_grant_reg <= REQ_SEQ;
    else
      last_grant_reg <= last_grant_next;
  end

endmodule

// File: rtl/pwm_cfg_arbiter.sv
// Sole writer of the PWM configuration bank: arbitrates SPI and sequencer writes,
// holds the enable registers, double-buffers the duty cycle and counts bad addresses.
module pwm_cfg_arbiter
  import pwm_cfg_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_wr_valid,
  output logic              spi_wr_ready,
  input  logic [ADDR_W-1:0] spi_wr_addr,
  input  logic [DATA_W-1:0] spi_wr_data,
  input  logic              seq_wr_valid,
  output logic              seq_wr_ready,
  input  logic [ADDR_W-1:0] seq_wr_addr,
  input  logic [DATA_W-1:0] seq_wr_data,
  input  logic              pwm_period_end,
  output logic [DATA_W-1:0] en_reg_7_0,
  output logic [DATA_W-1:0] en_reg_15_8,
  output logic [DATA_W-1:0] en_pwm_7_0,
  output logic [DATA_W-1:0] en_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              duty_pending,
  output logic              wr_err,
  output logic [7:0]        err_cnt
);

  logic [1:0]             req;
  logic [1:0]             gnt;
  logic                   wr_fire;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   addr_bad;
  logic                   duty_hit;
  logic [NUM_EN_REGS-1:0] en_we;

  logic [DATA_W-1:0] duty_reg, duty_next;
  logic [DATA_W-1:0] shadow_reg, shadow_next;
  logic              pending_reg, pending_next;
  logic              wr_err_reg, wr_err_next;
  logic [7:0]        err_cnt_reg, err_cnt_next;

  assign req[REQ_SPI] = spi_wr_valid;
  assign req[REQ_SEQ] = seq_wr_valid;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign spi_wr_ready = gnt[REQ_SPI];
  assign seq_wr_ready = gnt[REQ_SEQ];
  assign wr_fire      = |gnt;
  assign wr_addr      = gnt[REQ_SEQ] ? seq_wr_addr : spi_wr_addr;
  assign wr_data      = gnt[REQ_SEQ] ? seq_wr_data : spi_wr_data;
  assign addr_bad     = (wr_addr >= ADDR_W'(NUM_REGS));
  assign duty_hit     = wr_fire && (wr_addr == ADDR_W'(ADDR_DUTY));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_EN_REGS; gi++) begin : g_en
      logic [DATA_W-1:0] val_reg;

      assign en_we[gi] = wr_fire && (wr_addr == ADDR_W'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          val_reg <= '0;
        else if (en_we[gi])
          val_reg <= wr_data;
      end
    end
  endgenerate

  assign en_reg_7_0  = g_en[ADDR_EN_REG_LO].val_reg;
  assign en_reg_15_8 = g_en[ADDR_EN_REG_HI].val_reg;
  assign en_pwm_7_0  = g_en[ADDR_EN_PWM_LO].val_reg;
  assign en_pwm_15_8 = g_en[ADDR_EN_PWM_HI].val_reg;

  // A duty write landing on the period boundary goes straight to the live value.
  always_comb begin
    duty_next    = duty_reg;
    shadow_next  = shadow_reg;
    pending_next = pending_reg;
    if (duty_hit && pwm_period_end) begin
      duty_next    = wr_data;
      pending_next = 1'b0;
    end else if (duty_hit) begin
      shadow_next  = wr_data;
      pending_next = 1'b1;
    end else if (pwm_period_end && pending_reg) begin
      duty_next    = shadow_reg;
      pending_next = 1'b0;
    end
  end

  always_comb begin
    wr_err_next  = wr_fire && addr_bad;
    err_cnt_next = wr_err_next ? sat_inc8(err_cnt_reg) : err_cnt_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_reg    <= '0;
      shadow_reg  <= '0;
      pending_reg <= 1'b0;
      wr_err_reg  <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      duty_reg    <= duty_next;
      shadow_reg  <= shadow_next;
      pending_reg <= pending_next;
      wr_err_reg  <= wr_err_next;
      err_cnt_reg <= err_cnt_next;
    end
  end

  assign pwm_duty_cycle = duty_reg;
  assign duty_pending   = pending_reg;
  assign wr_err         = wr_err_reg;
  assign err_cnt        = err_cnt_reg;

endmodule
